// File: rtl/dco_tune_pkg.sv
// Shared types, bank geometry and saturation helper for the DCO tuning controller.
package dco_tune_pkg;

  localparam int unsigned N_L   = 5;
  localparam int unsigned N_M   = 16;
  localparam int unsigned N_S   = 16;
  localparam int unsigned L_MAX = 25;
  localparam int unsigned M_MAX = 256;
  localparam int unsigned S_MAX = 256;
  localparam int unsigned W_L   = 5;
  localparam int unsigned W_MS  = 9;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAKE,
    ST_IDLE,
    ST_UPD_L,
    ST_UPD_M,
    ST_UPD_S,
    ST_SETTLE
  } state_e;

  typedef struct packed {
    logic [W_L-1:0]  l;
    logic [W_MS-1:0] m;
    logic [W_MS-1:0] s;
  } tune_word_t;

  function automatic logic [W_MS-1:0] sat_word(input logic [W_MS-1:0] v,
                                              input logic [W_MS-1:0] vmax);
    return (v > vmax) ? vmax : v;
  endfunction

endpackage

// File: rtl/cap_bank_enc.sv
// Combinational encoder: binary cap count -> r_all/row/col drive of an N x N bank.
module cap_bank_enc #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] count,
  output logic [N-1:0] r_all,
  output logic [N-1:0] row,
  output logic [N-1:0] col
);

  logic [W-1:0] full;
  logic [W-1:0] rem;

  // full rows are switched whole; the partial row is selected by row and filled by col
  always_comb begin
    full  = count / W'(N);
    rem   = count % W'(N);
    r_all = '0;
    row   = '0;
    col   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      r_all[k] = full > W'(k);
      row[k]   = (rem != '0) && (full == W'(k));
      col[k]   = rem > W'(k);
    end
  end

endmodule

// File: rtl/dco_tune_ctrl.sv
// DCO tuning sequencer: wake-up, word accept with saturation, L->M->S bank update, settle.
module dco_tune_ctrl
  import dco_tune_pkg::*;
#(
  parameter int unsigned L_INIT     = 13,
  parameter int unsigned M_INIT     = 128,
  parameter int unsigned S_INIT     = 128,
  parameter int unsigned WAKE_CYC   = 16,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [W_L-1:0]   l_word,
  input  logic [W_MS-1:0]  m_word,
  input  logic [W_MS-1:0]  s_word,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             dco_en,
  output logic [N_L-1:0]   c_l_r_all,
  output logic [N_L-1:0]   c_l_row,
  output logic [N_L-1:0]   c_l_col,
  output logic [N_M-1:0]   c_m_r_all,
  output logic [N_M-1:0]   c_m_row,
  output logic [N_M-1:0]   c_m_col,
  output logic [N_S-1:0]   c_s_r_all,
  output logic [N_S-1:0]   c_s_row,
  output logic [N_S-1:0]   c_s_col,
  output logic             update_done,
  output logic             sat_flag
);

  localparam int unsigned CNT_MAX = (WAKE_CYC > SETTLE_CYC) ? WAKE_CYC : SETTLE_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  tune_word_t      word_q, word_d;
  logic            dco_en_q, dco_en_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            sat_q, sat_d;
  logic [N_L-1:0]  l_r_all_q, l_r_all_d, l_row_q, l_row_d, l_col_q, l_col_d;
  logic [N_M-1:0]  m_r_all_q, m_r_all_d, m_row_q, m_row_d, m_col_q, m_col_d;
  logic [N_S-1:0]  s_r_all_q, s_r_all_d, s_row_q, s_row_d, s_col_q, s_col_d;

  logic [W_L-1:0]  l_cnt_c;
  logic [W_MS-1:0] m_cnt_c, s_cnt_c;
  logic [N_L-1:0]  l_r_all_e, l_row_e, l_col_e;
  logic [N_M-1:0]  m_r_all_e, m_row_e, m_col_e;
  logic [N_S-1:0]  s_r_all_e, s_row_e, s_col_e;

  // encoders see the wake-up presets while OFF, the captured word otherwise
  assign l_cnt_c = (state_q == ST_OFF) ? W_L'(L_INIT)  : word_q.l;
  assign m_cnt_c = (state_q == ST_OFF) ? W_MS'(M_INIT) : word_q.m;
  assign s_cnt_c = (state_q == ST_OFF) ? W_MS'(S_INIT) : word_q.s;

  cap_bank_enc #(.N(N_L), .W(W_L)) u_enc_l (
    .count(l_cnt_c), .r_all(l_r_all_e), .row(l_row_e), .col(l_col_e)
  );
  cap_bank_enc #(.N(N_M), .W(W_MS)) u_enc_m (
    .count(m_cnt_c), .r_all(m_r_all_e), .row(m_row_e), .col(m_col_e)
  );
  cap_bank_enc #(.N(N_S), .W(W_MS)) u_enc_s (
    .count(s_cnt_c), .r_all(s_r_all_e), .row(s_row_e), .col(s_col_e)
  );

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    dco_en_d  = dco_en_q;
    done_d    = 1'b0;
    sat_d     = sat_q;
    l_r_all_d = l_r_all_q; l_row_d = l_row_q; l_col_d = l_col_q;
    m_r_all_d = m_r_all_q; m_row_d = m_row_q; m_col_d = m_col_q;
    s_r_all_d = s_r_all_q; s_row_d = s_row_q; s_col_d = s_col_q;

    unique case (state_q)
      ST_OFF: begin
        if (en_i) begin
          state_d   = ST_WAKE;
          l_r_all_d = l_r_all_e; l_row_d = l_row_e; l_col_d = l_col_e;
          m_r_all_d = m_r_all_e; m_row_d = m_row_e; m_col_d = m_col_e;
          s_r_all_d = s_r_all_e; s_row_d = s_row_e; s_col_d = s_col_e;
        end
      end
      ST_WAKE: begin
        if (cnt_q == CW'(WAKE_CYC - 1)) begin
          state_d  = ST_IDLE;
          dco_en_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (word_valid) begin
          state_d  = ST_UPD_L;
          word_d.l = W_L'(sat_word(W_MS'(l_word), W_MS'(L_MAX)));
          word_d.m = sat_word(m_word, W_MS'(M_MAX));
          word_d.s = sat_word(s_word, W_MS'(S_MAX));
          sat_d    = sat_q | (l_word > W_L'(L_MAX)) | (m_word > W_MS'(M_MAX))
                           | (s_word > W_MS'(S_MAX));
        end
      end
      ST_UPD_L: begin
        state_d   = ST_UPD_M;
        l_r_all_d = l_r_all_e; l_row_d = l_row_e; l_col_d = l_col_e;
      end
      ST_UPD_M: begin
        state_d   = ST_UPD_S;
        m_r_all_d = m_r_all_e; m_row_d = m_row_e; m_col_d = m_col_e;
      end
      ST_UPD_S: begin
        s_r_all_d = s_r_all_e; s_row_d = s_row_e; s_col_d = s_col_e;
        if (SETTLE_CYC == 0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase

    // disable wins over sequencing, but a bank latched this edge still lands
    if (!en_i) begin
      state_d  = ST_OFF;
      dco_en_d = 1'b0;
      done_d   = 1'b0;
      word_d   = word_q;
      sat_d    = sat_q;
    end

    cnt_d   = (state_d != state_q) ? '0 : cnt_q + CW'(1);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      word_q    <= '0;
      dco_en_q  <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
      l_r_all_q <= '0; l_row_q <= '0; l_col_q <= '0;
      m_r_all_q <= '0; m_row_q <= '0; m_col_q <= '0;
      s_r_all_q <= '0; s_row_q <= '0; s_col_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      dco_en_q  <= dco_en_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
      l_r_all_q <= l_r_all_d; l_row_q <= l_row_d; l_col_q <= l_col_d;
      m_r_all_q <= m_r_all_d; m_row_q <= m_row_d; m_col_q <= m_col_d;
      s_r_all_q <= s_r_all_d; s_row_q <= s_row_d; s_col_q <= s_col_d;
    end
  end

  assign word_ready  = ready_q;
  assign dco_en      = dco_en_q;
  assign update_done = done_q;
  assign sat_flag    = sat_q;
  assign c_l_r_all   = l_r_all_q;
  assign c_l_row     = l_row_q;
  assign c_l_col     = l_col_q;
  assign c_m_r_all   = m_r_all_q;
  assign c_m_row     = m_row_q;
  assign c_m_col     = m_col_q;
  assign c_s_r_all   = s_r_all_q;
  assign c_s_row     = s_row_q;
  assign c_s_col     = s_col_q;

endmodule
